// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, register map and STATUS layout.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_FRAME_ERR = 2;
    localparam int STAT_OVERRUN   = 3;
    localparam int STAT_COUNT_LSB = 8;

    localparam int DEFAULT_CLKS_PER_BIT = 87;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head so a pushed word is readable the next cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (PTR_W+1)'(DEPTH));
    assign count = count_reg;
    assign dout  = mem[rd_ptr_reg];

    // A push into a full FIFO is only accepted when the same cycle frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1) feeding a byte FIFO, exposed as a two-register processor peripheral.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        addr_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [31:0] entrada_i,
    output logic [31:0] salida_o,
    output logic        irq_o
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int BAUD_W   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF_BIT - 1);

    logic [1:0]        sync_reg;
    logic              rxs;
    logic              rxs_prev_reg;

    rx_state_t         state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg, baud_next;
    logic [2:0]        bit_reg, bit_next;
    logic [7:0]        shift_reg, shift_next;
    logic              push;
    logic              frame_bad;

    logic              overrun_reg;
    logic              frame_err_reg;

    logic [7:0]        fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              is_status;
    logic              clr_overrun;
    logic              clr_frame_err;
    logic [31:0]       status_word;
    logic              unused_entrada;

    // The line is asynchronous; only the second flop's output is trusted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg     <= 2'b11;
            rxs_prev_reg <= 1'b1;
        end else begin
            sync_reg     <= {sync_reg[0], rx};
            rxs_prev_reg <= rxs;
        end
    end

    assign rxs = sync_reg[1];

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        push       = 1'b0;
        frame_bad  = 1'b0;
        case (state_reg)
            IDLE: begin
                baud_next = '0;
                bit_next  = '0;
                // Only a falling edge starts a frame, so a line stuck low is ignored.
                if (rxs_prev_reg && !rxs) begin
                    state_next = START;
                end
            end
            START: begin
                if (baud_reg == HALF_LAST) begin
                    baud_next  = '0;
                    state_next = rxs ? IDLE : DATA;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_reg == BIT_LAST) begin
                    baud_next  = '0;
                    shift_next = {rxs, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_reg == BIT_LAST) begin
                    baud_next  = '0;
                    state_next = IDLE;
                    push       = rxs;
                    frame_bad  = !rxs;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (rst),
        .push  (push),
        .pop   (pop),
        .din   (shift_reg),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign is_status     = (addr_i == ADDR_STATUS);
    assign pop           = rd_i && !is_status && !fifo_empty;
    assign clr_overrun   = wr_i && is_status && entrada_i[STAT_OVERRUN];
    assign clr_frame_err = wr_i && is_status && entrada_i[STAT_FRAME_ERR];
    assign unused_entrada = ^{entrada_i[31:4], entrada_i[1:0]};

    // Set events take priority over a same-cycle software clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            overrun_reg   <= (push && fifo_full && !pop) || (overrun_reg && !clr_overrun);
            frame_err_reg <= frame_bad || (frame_err_reg && !clr_frame_err);
        end
    end

    always_comb begin
        status_word                          = '0;
        status_word[STAT_NOT_EMPTY]          = !fifo_empty;
        status_word[STAT_FULL]               = fifo_full;
        status_word[STAT_FRAME_ERR]          = frame_err_reg;
        status_word[STAT_OVERRUN]            = overrun_reg;
        status_word[STAT_COUNT_LSB +: 8]     = 8'(fifo_count);
    end

    assign salida_o = is_status  ? status_word :
                      fifo_empty ? 32'h0       : {24'h0, fifo_dout};
    assign irq_o    = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized frames against a queue-based model of the receive FIFO and flags.
module tb_uart_rx_fifo;

    localparam int CPB      = 87;
    localparam int DEPTH    = 8;
    localparam int FRAME_C  = 10 * CPB;
    // Edge index (counted from the start-bit drive) at which the stop bit is sampled.
    localparam int SAMPLE_E = 3 + CPB / 2 + 9 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        addr_i;
    logic        rd_i;
    logic        wr_i;
    logic [31:0] entrada_i;
    logic [31:0] salida_o;
    logic        irq_o;

    int tests = 0;
    int fails = 0;

    logic [7:0] q[$];
    bit         ovr;
    bit         ferr;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .addr_i    (addr_i),
        .rd_i      (rd_i),
        .wr_i      (wr_i),
        .entrada_i (entrada_i),
        .salida_o  (salida_o),
        .irq_o     (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = 32'h0;
        s[15:8] = 8'(q.size());
        s[3]    = ovr;
        s[2]    = ferr;
        s[1]    = (q.size() == DEPTH);
        s[0]    = (q.size() != 0);
        return s;
    endfunction

    task automatic model_reset();
        q.delete();
        ovr  = 1'b0;
        ferr = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] d, input bit stop);
        if (!stop) begin
            ferr = 1'b1;
        end else if (q.size() < DEPTH) begin
            q.push_back(d);
        end else begin
            ovr = 1'b1;
        end
    endtask

    task automatic peek_status(output logic [31:0] d);
        @(negedge clk);
        addr_i = 1'b1;
        #1 d = salida_o;
        addr_i = 1'b0;
    endtask

    task automatic read_status(input string tag);
        logic [31:0] d;
        peek_status(d);
        check(tag, d, exp_status());
        check({tag, "_irq"}, {31'h0, irq_o}, {31'h0, q.size() != 0});
    endtask

    task automatic read_data(input string tag, output logic [31:0] d);
        logic [31:0] exp;
        @(negedge clk);
        addr_i = 1'b0;
        rd_i   = 1'b1;
        #1 d = salida_o;
        exp = (q.size() != 0) ? {24'h0, q[0]} : 32'h0;
        check(tag, d, exp);
        @(posedge clk);
        #1 rd_i = 1'b0;
        if (q.size() != 0) q.delete(0);
    endtask

    task automatic write_reg(input logic a, input logic [31:0] v);
        @(negedge clk);
        addr_i    = a;
        wr_i      = 1'b1;
        entrada_i = v;
        @(posedge clk);
        #1 wr_i   = 1'b0;
        addr_i    = 1'b0;
        entrada_i = 32'h0;
        if (a) begin
            if (v[3]) ovr = 1'b0;
            if (v[2]) ferr = 1'b0;
        end
    endtask

    // Drives one 8N1 frame; optionally pulses a DATA read or a reset at given cycles.
    task automatic send_frame(input logic [7:0] d, input bit stop, input int pop_c, input int rst_c,
                              output logic [31:0] popped, output logic irq_pre, output logic irq_post);
        int b;
        popped   = 32'h0;
        irq_pre  = 1'b0;
        irq_post = 1'b0;
        for (int c = 0; c < FRAME_C; c++) begin
            @(negedge clk);
            b = c / CPB;
            if (b == 0)      rx = 1'b0;
            else if (b == 9) rx = stop;
            else             rx = d[b-1];
            rst = (rst_c >= 0 && c >= rst_c && c < rst_c + 3);
            if (c == pop_c) begin
                addr_i = 1'b0;
                rd_i   = 1'b1;
            end else begin
                rd_i = 1'b0;
            end
            #1;
            if (c == pop_c) popped = salida_o;
            if (c == SAMPLE_E - 1) irq_pre = irq_o;
            if (c == SAMPLE_E) irq_post = irq_o;
        end
        @(negedge clk);
        rx   = 1'b1;
        rd_i = 1'b0;
        rst  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] popped;
        logic        ipre;
        logic        ipost;
        logic [7:0]  rb;
        bit          rstop;

        rst       = 1'b1;
        rx        = 1'b1;
        addr_i    = 1'b0;
        rd_i      = 1'b0;
        wr_i      = 1'b0;
        entrada_i = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset_irq", {31'h0, irq_o}, 32'h0);
        peek_status(d);
        check("reset_status", d, 32'h0);
        @(negedge clk);
        #1 check("reset_data", salida_o, 32'h0);

        // Single byte: irq timing, STATUS and DATA contents.
        send_frame(8'h55, 1'b1, -1, -1, popped, ipre, ipost);
        model_frame(8'h55, 1'b1);
        check("b55_irq_before_sample", {31'h0, ipre}, 32'h0);
        check("b55_irq_after_sample", {31'h0, ipost}, 32'h1);
        peek_status(d);
        check("b55_status", d, 32'h101);
        read_data("b55_data", d);
        check("b55_data_const", d, 32'h55);
        peek_status(d);
        check("b55_status_empty", d, 32'h0);
        check("b55_irq_empty", {31'h0, irq_o}, 32'h0);

        // Nine bytes into an eight-deep FIFO.
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 1'b1, -1, -1, popped, ipre, ipost);
            model_frame(8'(i), 1'b1);
        end
        peek_status(d);
        check("ovr_status", d, 32'h80B);
        for (int i = 1; i <= 8; i++) begin
            read_data($sformatf("ovr_data%0d", i), d);
            check($sformatf("ovr_const%0d", i), d, 32'(i));
        end
        write_reg(1'b0, 32'hFFFF_FFFF);
        read_status("data_write_ignored");
        write_reg(1'b1, 32'h8);
        read_status("ovr_cleared");

        // Bad stop bit.
        send_frame(8'hA3, 1'b0, -1, -1, popped, ipre, ipost);
        model_frame(8'hA3, 1'b0);
        peek_status(d);
        check("ferr_status", d, 32'h004);
        write_reg(1'b1, 32'h4);
        peek_status(d);
        check("ferr_cleared", d, 32'h0);

        // Short low glitch on an idle line.
        @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        peek_status(d);
        check("glitch_status", d, 32'h0);
        send_frame(8'h5A, 1'b1, -1, -1, popped, ipre, ipost);
        model_frame(8'h5A, 1'b1);
        read_data("glitch_next_byte", d);
        check("glitch_next_const", d, 32'h5A);

        // Full FIFO with a DATA read landing on the push cycle.
        for (int i = 0; i < DEPTH; i++) begin
            rb = 8'($urandom_range(0, 255));
            send_frame(rb, 1'b1, -1, -1, popped, ipre, ipost);
            model_frame(rb, 1'b1);
        end
        rb = 8'($urandom_range(0, 255));
        send_frame(rb, 1'b1, SAMPLE_E - 1, -1, popped, ipre, ipost);
        check("fullpop_oldest", popped, {24'h0, q[0]});
        q.delete(0);
        q.push_back(rb);
        peek_status(d);
        check("fullpop_status", d, 32'h803);
        read_status("fullpop_model");
        for (int i = 0; i < DEPTH; i++) begin
            read_data($sformatf("fullpop_drain%0d", i), d);
        end
        read_status("fullpop_empty");

        // Reset in the middle of a frame.
        send_frame(8'hF0, 1'b1, -1, 5 * CPB + 10, popped, ipre, ipost);
        model_reset();
        send_frame(8'h3C, 1'b1, -1, -1, popped, ipre, ipost);
        model_frame(8'h3C, 1'b1);
        peek_status(d);
        check("rstmid_status", d, 32'h101);
        read_data("rstmid_data", d);
        check("rstmid_const", d, 32'h3C);

        // Randomized frames, reads and flag clears.
        for (int n = 0; n < 10; n++) begin
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 3) != 0);
            send_frame(rb, rstop, -1, -1, popped, ipre, ipost);
            model_frame(rb, rstop);
            read_status($sformatf("rnd%0d_status", n));
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                read_data($sformatf("rnd%0d_read%0d", n, k), d);
            end
            if ($urandom_range(0, 2) == 0) begin
                write_reg(1'b1, $urandom);
                read_status($sformatf("rnd%0d_clear", n));
            end
        end
        while (q.size() != 0) begin
            read_data("final_drain", d);
        end
        read_data("final_empty_read", d);
        read_status("final_status");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, clk cycles per UART bit (10 MHz / 115200).
REQ-002 Parameter FIFO_DEPTH, default 8, receive FIFO entries; power of two, 2..64.
REQ-003 Ports, clock and reset first:
- clk  input  1  system clock (clk_10Mhz domain).
- rst  input  1  synchronous reset, active-high.
- rx  input  1  asynchronous UART line, idle high.
- addr_i  input  1  register select: 0 = DATA, 1 = STATUS.
- rd_i  input  1  processor read strobe.
- wr_i  input  1  processor write strobe.
- entrada_i  input  32  processor write data.
- salida_o  output  32  register read data, combinational from addr_i.
- irq_o  output  1  high while FIFO is non-empty.
REQ-004 One clock domain (clk). Reset is synchronous and active-high on rst.

Function
REQ-005 rx passes through a 2-flop synchronizer with reset value 1; all logic uses the synchronized value rxs.
REQ-006 FSM states: IDLE, START, DATA, STOP.
REQ-007 IDLE: a 1->0 transition on rxs starts a frame: go to START with the bit counter cleared. A level held low does not start a new frame.
REQ-008 START: after CLKS_PER_BIT/2 cycles (integer divide), sample rxs. A 0 goes to DATA. A 1 is a glitch and returns to IDLE with no flag set.
REQ-009 DATA: sample rxs every CLKS_PER_BIT cycles. Receive 8 bits, LSB first, into the shift register. Go to STOP after bit 7.
REQ-010 STOP: sample rxs after CLKS_PER_BIT cycles.
- rxs = 1: push the byte.
- rxs = 0: set frame_err and discard the byte.
- Either case: return to IDLE.
REQ-011 Pushed byte is visible at the FIFO head / count on the cycle after the stop-bit sample.
REQ-012 Push into a full FIFO with no same-cycle pop: byte dropped, overrun set, FIFO contents unchanged.
REQ-013 DATA read: salida_o = {24'b0, head}. Returns 32'h0 when empty.
REQ-014 Pop on the clk edge where rd_i=1 and addr_i=0 and the FIFO is non-empty. Pop when empty has no effect.
REQ-015 Simultaneous push and pop: both take effect and count is unchanged. This also applies when full; no overrun is flagged.
REQ-016 STATUS read: salida_o = {16'b0, count[7:0], 4'b0, overrun, frame_err, full, not_empty}.
REQ-017 Write (wr_i=1) to STATUS with entrada_i[3]=1 clears overrun; entrada_i[2]=1 clears frame_err. A set event in the same cycle wins over the clear.
REQ-018 Writes to DATA are ignored. rd_i to STATUS has no side effects.
REQ-019 rd_i and wr_i both high: both actions apply.
REQ-020 FIFO pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH. full = (count == FIFO_DEPTH).
REQ-021 irq_o = not_empty, registered-free (derived from count).

Reset
REQ-022 On rst=1 at a clk edge, the following return to their reset values:
- FSM to IDLE.
- Bit and baud counters to 0.
- Synchronizer to 1.
- FIFO pointers and count to 0.
- overrun and frame_err to 0.
REQ-023 After reset: irq_o = 0; salida_o = 0 for DATA; salida_o = 0 for STATUS.
REQ-024 Reset mid-frame aborts the frame with no push. Reception resumes only on a new 1->0 edge after rst deasserts.

Structure
REQ-025 Shared package uart_pkg holds:
- the FSM state enum (rx_state_t);
- DATA/STATUS address constants;
- STATUS bit indices;
- the default CLKS_PER_BIT.
REQ-026 FIFO is a sub-module sync_fifo (parameters WIDTH=8, DEPTH) with push, pop, data in/out, count, full, empty. uart_rx_fifo holds the synchronizer, FSM and register decode.
REQ-027 The block connects to the existing deco_uart/mux_read path exactly as the IPU does, with no change to unicycle.

Verification
REQ-028 Byte 0x55 sent at 87 clk/bit, stop=1:
- one cycle after the stop sample, irq_o=1;
- STATUS reads 0x101;
- DATA read returns 0x55;
- then STATUS reads 0x000 and irq_o=0.
REQ-029 Nine bytes 0x01..0x09 sent with no reads (FIFO_DEPTH=8):
- STATUS = 0x80B (count 8, overrun, full, not_empty);
- eight DATA reads return 0x01..0x08 in order.
REQ-030 Frame 0xA3 with stop bit 0:
- nothing is pushed and frame_err=1;
- a STATUS write of 0x4 clears frame_err to 0.
REQ-031 A 20-cycle low glitch on idle rx produces no push, no flags, and FSM back in IDLE.
REQ-032 FIFO full, DATA read issued on the same cycle as a push:
- count stays 8 and overrun stays 0;
- the popped value is the oldest byte.
REQ-033 rst asserted during DATA bit 4 of byte 0xF0, then byte 0x3C sent: FIFO holds only 0x3C.
